// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALU
// operation codes and datapath select values (also imported by alu_control).
package control_fsm_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC   = 4'd2;
    localparam logic [3:0] ST_ALU_WB = 4'd3;
    localparam logic [3:0] ST_MEM_RD = 4'd4;
    localparam logic [3:0] ST_MEM_WR = 4'd5;
    localparam logic [3:0] ST_BRANCH = 4'd6;
    localparam logic [3:0] ST_JUMP   = 4'd7;
    localparam logic [3:0] ST_HALT   = 4'd8;
    localparam logic [3:0] ST_ERROR  = 4'd9;

    localparam logic [4:0] OP_LOAD  = 5'b00110;
    localparam logic [4:0] OP_STORE = 5'b00111;
    localparam logic [4:0] OP_BEQ   = 5'b10100;
    localparam logic [4:0] OP_JUMP  = 5'b10101;
    localparam logic [4:0] OP_ALTER = 5'b11110;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ALTER = 2'b11
    } alu_op_e;

    localparam logic [1:0] SRCB_MEM = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       acc_write;
        logic       acc_src;
        logic [1:0] pc_source;
    } ctrl_t;

    // ALTER-class instructions take their ALU function from a separate field.
    function automatic alu_op_e exec_alu_op(input logic [4:0] opcode);
        return (opcode == OP_ALTER) ? ALUOP_ALTER : ALUOP_FUNCT;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Datapath control bundle: status from the datapath in, strobes/selects out.
interface control_fsm_if;
    logic [4:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       acc_write;
    logic       acc_src;
    logic [1:0] pc_source;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_write, ir_write, mem_read,
               mem_write, iord, acc_write, acc_src, pc_source
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_write, ir_write, mem_read,
               mem_write, iord, acc_write, acc_src, pc_source
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the last allowed one.
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/control_fsm.sv
// Multicycle accumulator-machine control FSM with memory-handshake timeout.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    control_fsm_if.master        bus,
    output logic                 halted_o,
    output logic                 error_o,
    output logic [3:0]           state_o
);
    logic [3:0] state_q, state_d;
    logic       expired;
    logic       wait_en;
    logic       wait_clear;
    ctrl_t      ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = (state_q == ST_FETCH) ? ST_DECODE : ST_FETCH;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LOAD:  state_d = ST_MEM_RD;
                    OP_STORE: state_d = ST_MEM_WR;
                    OP_BEQ:   state_d = ST_BRANCH;
                    OP_JUMP:  state_d = ST_JUMP;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_EXEC;
                endcase
            end
            ST_EXEC:   state_d = ST_ALU_WB;
            ST_ALU_WB: state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Any state change restarts the count, so each memory state starts at zero.
    assign wait_en    = (state_q inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR}) && !bus.mem_ready;
    assign wait_clear = (state_d != state_q);

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wait_clear),
        .enable_i  (wait_en),
        .expired_o (expired)
    );

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            ST_EXEC, ST_ALU_WB: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = exec_alu_op(bus.opcode);
                ctrl.acc_write = (state_q == ST_ALU_WB);
            end
            ST_MEM_RD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.acc_src   = 1'b1;
                ctrl.acc_write = bus.mem_ready;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_MEM;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_BRANCH;
                ctrl.pc_write  = bus.zero;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

    // Reset forces a quiet datapath even before the state register updates.
    assign bus.alu_op    = rst_i ? 2'b00 : ctrl.alu_op;
    assign bus.alu_src_a = ctrl.alu_src_a & ~rst_i;
    assign bus.alu_src_b = rst_i ? 2'b00 : ctrl.alu_src_b;
    assign bus.pc_write  = ctrl.pc_write  & ~rst_i;
    assign bus.ir_write  = ctrl.ir_write  & ~rst_i;
    assign bus.mem_read  = ctrl.mem_read  & ~rst_i;
    assign bus.mem_write = ctrl.mem_write & ~rst_i;
    assign bus.iord      = ctrl.iord      & ~rst_i;
    assign bus.acc_write = ctrl.acc_write & ~rst_i;
    assign bus.acc_src   = ctrl.acc_src   & ~rst_i;
    assign bus.pc_source = rst_i ? 2'b00 : ctrl.pc_source;

    assign halted_o = (state_q == ST_HALT)  && !rst_i;
    assign error_o  = (state_q == ST_ERROR) && !rst_i;
    assign state_o  = rst_i ? ST_FETCH : state_q;
endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm.
module tb_control_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       halted;
    logic       error;
    logic [3:0] state;
    logic [15:0] outs;
    int pass_cnt = 0;
    int total    = 0;

    control_fsm_if bus ();

    control_fsm #(
        .MEM_TIMEOUT (15)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus),
        .halted_o (halted),
        .error_o  (error),
        .state_o  (state)
    );

    always #5 clk = ~clk;

    assign outs = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_write, bus.ir_write,
                   bus.mem_read, bus.mem_write, bus.iord, bus.acc_write, bus.acc_src,
                   bus.pc_source, halted, error};

    function automatic logic [15:0] v(input logic [1:0] aop, input logic sa, input logic [1:0] sb,
                                      input logic pcw, input logic irw, input logic mr,
                                      input logic mw, input logic iord, input logic aw,
                                      input logic asrc, input logic [1:0] pcs,
                                      input logic h, input logic e);
        return {aop, sa, sb, pcw, irw, mr, mw, iord, aw, asrc, pcs, h, e};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 5'b00000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_outs", outs, 16'h0000);
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_outs_rdy", outs, 16'h0000);

        // ALU instruction: FETCH, DECODE, EXEC, ALU_WB, FETCH
        rst = 1'b0;
        bus.opcode = 5'b00001;
        #1;
        chk("alu_fetch_state", 16'(state), 16'd0);
        chk("alu_fetch_outs", outs, v(2'b00, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        tick();
        chk("alu_decode_state", 16'(state), 16'd1);
        chk("alu_decode_outs", outs, 16'h0000);
        tick();
        chk("alu_exec_state", 16'(state), 16'd2);
        chk("alu_exec_outs", outs, v(2'b10, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        tick();
        chk("alu_wb_state", 16'(state), 16'd3);
        chk("alu_wb_outs", outs, v(2'b10, 1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0));
        tick();
        chk("alu_back_fetch", 16'(state), 16'd0);

        // ALTER instruction
        bus.opcode = 5'b11110;
        tick();
        tick();
        chk("alter_exec_outs", outs, v(2'b11, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        tick();
        chk("alter_wb_outs", outs, v(2'b11, 1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0));
        tick();
        chk("alter_back_fetch", 16'(state), 16'd0);

        // Branch not taken, then taken
        bus.opcode = 5'b10100;
        bus.zero = 1'b0;
        tick();
        tick();
        chk("beq_nt_state", 16'(state), 16'd6);
        chk("beq_nt_outs", outs, v(2'b01, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0));
        tick();
        chk("beq_nt_fetch", 16'(state), 16'd0);
        bus.zero = 1'b1;
        tick();
        tick();
        chk("beq_t_outs", outs, v(2'b01, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0));
        tick();
        chk("beq_t_fetch", 16'(state), 16'd0);
        bus.zero = 1'b0;

        // Jump
        bus.opcode = 5'b10101;
        tick();
        tick();
        chk("jump_state", 16'(state), 16'd7);
        chk("jump_outs", outs, v(2'b00, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
        tick();
        chk("jump_fetch", 16'(state), 16'd0);

        // Load with three stall cycles
        bus.opcode = 5'b00110;
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("load_wait_state", 16'(state), 16'd4);
            chk("load_wait_outs", outs, v(2'b00, 0, 2'b00, 0, 0, 1, 0, 1, 0, 1, 2'b00, 0, 0));
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("load_done_outs", outs, v(2'b00, 0, 2'b00, 0, 0, 1, 0, 1, 1, 1, 2'b00, 0, 0));
        tick();
        chk("load_fetch_state", 16'(state), 16'd0);
        chk("load_fetch_outs", outs, v(2'b00, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0));

        // Store
        bus.opcode = 5'b00111;
        tick();
        tick();
        chk("store_state", 16'(state), 16'd5);
        chk("store_outs", outs, v(2'b00, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0));
        tick();
        chk("store_fetch", 16'(state), 16'd0);

        // FETCH timeout: 15 stalled cycles then ERROR
        bus.mem_ready = 1'b0;
        #1;
        chk("fetch_stall_outs", outs, v(2'b00, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk($sformatf("fetch_stall_%0d", i), 16'(state), 16'd0);
        end
        tick();
        chk("timeout_state", 16'(state), 16'd9);
        chk("timeout_outs", outs, v(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        bus.mem_ready = 1'b1;
        tick();
        chk("error_sticky", outs, v(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        rst = 1'b1;
        #1;
        chk("err_rst_state", 16'(state), 16'd0);
        chk("err_rst_outs", outs, 16'h0000);
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("err_clear_state", 16'(state), 16'd0);

        // Ready on the 15th stalled cycle wins over the timeout
        bus.opcode = 5'b00001;
        for (int i = 1; i <= 14; i++) tick();
        chk("stall14_state", 16'(state), 16'd0);
        bus.mem_ready = 1'b1;
        tick();
        chk("late_ready_decode", 16'(state), 16'd1);
        tick();
        tick();
        tick();
        chk("late_ready_fetch", 16'(state), 16'd0);

        // Reset in the middle of a store aborts it and restarts the counter
        bus.opcode = 5'b00111;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        chk("abort_in_mem_wr", 16'(state), 16'd5);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_fetch_state", 16'(state), 16'd0);
        for (int i = 1; i <= 14; i++) tick();
        chk("abort_cnt_14", 16'(state), 16'd0);
        tick();
        chk("abort_cnt_15", 16'(state), 16'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // HALT is sticky until reset
        bus.mem_ready = 1'b1;
        bus.opcode = 5'b11111;
        tick();
        tick();
        chk("halt_state", 16'(state), 16'd8);
        chk("halt_outs", outs, v(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("halt_hold", {15'd0, halted}, 16'd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("halt_rst_state", 16'(state), 16'd0);
        chk("halt_rst_halted", {15'd0, halted}, 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
